// File: rtl/isa_pkg.sv
// Shared ISA constants and fetch FSM state type for the instruction fetch unit.
package isa_pkg;

    localparam int IW = 9;

    localparam logic [IW-1:0] OP_NOP  = 9'b111111110;
    localparam logic [IW-1:0] OP_DONE = 9'b111111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// Program counter register with clear, branch load and wrapping increment.
module program_counter #(
    parameter int PC_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                load,
    input  logic                advance,
    input  logic [PC_WIDTH-1:0] load_value,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] pc_reg;
    logic [PC_WIDTH-1:0] pc_next;

    // Increment wraps naturally at 2^PC_WIDTH.
    always_comb begin
        pc_next = pc_reg;
        if (clear) begin
            pc_next = '0;
        end else if (load) begin
            pc_next = load_value;
        end else if (advance) begin
            pc_next = pc_reg + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= '0;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: IDLE/RUN/HALT sequencing, branch bubble, DONE halt.
// Optional FETCH_PERF_EN adds cycle_count and bubble_count performance counters.
module instr_fetch #(
    parameter int PC_WIDTH = 10,
    parameter int IW       = isa_pkg::IW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [IW-1:0]       imem_data,
    output logic [IW-1:0]       instr,
    output logic                instr_valid,
    input  logic                branch,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] target,
    output logic                done
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         cycle_count,
    output logic [15:0]         bubble_count
`endif
);

    import isa_pkg::*;

    localparam logic [IW-1:0] NOP_WORD  = IW'(OP_NOP);
    localparam logic [IW-1:0] DONE_WORD = IW'(OP_DONE);

    fetch_state_t        state_reg, state_next;
    logic [IW-1:0]       instr_reg, instr_next;
    logic                valid_reg, valid_next;
    logic                done_reg, done_next;
    logic                pc_clear, pc_load, pc_advance;
    logic                bubble;
    logic [PC_WIDTH-1:0] pc;

    program_counter #(
        .PC_WIDTH(PC_WIDTH)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (pc_clear),
        .load       (pc_load),
        .advance    (pc_advance),
        .load_value (target),
        .pc         (pc)
    );

    always_comb begin
        state_next = state_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
        done_next  = done_reg;
        pc_clear   = 1'b0;
        pc_load    = 1'b0;
        pc_advance = 1'b0;
        bubble     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                instr_next = NOP_WORD;
                valid_next = 1'b0;
                done_next  = 1'b0;
                pc_clear   = 1'b1;
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Stall freezes everything, including DONE and redirect detection.
                if (!stall) begin
                    if (valid_reg && (instr_reg == DONE_WORD)) begin
                        state_next = ST_HALT;
                        instr_next = NOP_WORD;
                        valid_next = 1'b0;
                        done_next  = 1'b1;
                    end else if (valid_reg && branch && branch_taken) begin
                        pc_load    = 1'b1;
                        instr_next = NOP_WORD;
                        valid_next = 1'b0;
                        bubble     = 1'b1;
                    end else begin
                        instr_next = imem_data;
                        valid_next = 1'b1;
                        pc_advance = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                instr_next = NOP_WORD;
                valid_next = 1'b0;
                done_next  = 1'b1;
                if (start) begin
                    state_next = ST_RUN;
                    done_next  = 1'b0;
                    pc_clear   = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                instr_next = NOP_WORD;
                valid_next = 1'b0;
                done_next  = 1'b0;
                pc_clear   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            instr_reg <= NOP_WORD;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
        end
    end

    assign imem_addr   = pc;
    assign instr       = instr_reg;
    assign instr_valid = valid_reg;
    assign done        = done_reg;

`ifdef FETCH_PERF_EN
    logic [31:0] cycle_count_reg;
    logic [15:0] bubble_count_reg;
    logic        perf_clear;

    // Start is only accepted outside RUN, so only then does it restart the counters.
    assign perf_clear = start && (state_reg != ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_reg  <= '0;
            bubble_count_reg <= '0;
        end else if (perf_clear) begin
            cycle_count_reg  <= '0;
            bubble_count_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
            if (bubble) begin
                bubble_count_reg <= bubble_count_reg + 16'd1;
            end
        end
    end

    assign cycle_count  = cycle_count_reg;
    assign bubble_count = bubble_count_reg;
`else
    logic unused_bubble;
    assign unused_bubble = bubble;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 PC_WIDTH, default 10, meaning: program counter and instruction-memory address width.
REQ-002 IW, default 9, meaning: instruction word width.
REQ-003 Clk  input  1  meaning: single clock; all state updates on its rising edge.
REQ-004 Reset_n  input  1  meaning: asynchronous, active-low reset.
REQ-005 Start  input  1  meaning: one-cycle pulse that begins execution at address 0.
REQ-006 Stall  input  1  meaning: freezes all fetch state while high.
REQ-007 ImemAddr  output  PC_WIDTH  meaning: instruction-memory read address, equal to PC.
REQ-008 ImemData  input  IW  meaning: combinational instruction-memory read data for ImemAddr.
REQ-009 Instr  output  IW  meaning: registered instruction presented to the control decoder.
REQ-010 InstrValid  output  1  meaning: Instr is a real instruction to be executed.
REQ-011 Branch  input  1  meaning: decoder flag that the current Instr is a branch.
REQ-012 BranchTaken  input  1  meaning: branch condition flag evaluated for the current Instr.
REQ-013 Target  input  PC_WIDTH  meaning: branch destination address for the current Instr.
REQ-014 Done  output  1  meaning: program has executed the DONE instruction and halted.

Function
REQ-015 The block SHALL implement states IDLE, RUN, HALT.
REQ-016 IDLE: PC held at 0, Instr = NOP (9'b111111110), InstrValid = 0, Done = 0; Start -> RUN.
REQ-017 RUN, Stall low, no redirect, no DONE: Instr <= ImemData, InstrValid <= 1, PC <= PC+1 each cycle.
REQ-018 Fetch latency SHALL be one cycle: the word at address A appears on Instr the cycle after PC = A.
REQ-019 Redirect: in RUN with Stall low, InstrValid, Branch and BranchTaken all high, the block SHALL set PC <= Target and Instr <= NOP with InstrValid <= 0 (one bubble; the fetched word is squashed).
REQ-020 Branch high with BranchTaken low SHALL cause sequential fetch with no bubble.
REQ-021 DONE: when InstrValid and Instr = 9'b111111111 with Stall low, the block SHALL enter HALT; the word fetched that cycle is discarded.
REQ-022 HALT: Done = 1, InstrValid = 0, Instr = NOP, PC held; Start -> RUN with PC = 0 and Done cleared.
REQ-023 Start SHALL be ignored in RUN.
REQ-024 Stall high SHALL hold PC, Instr, InstrValid, state and Done unchanged, and SHALL suppress redirect and DONE detection.
REQ-025 Priority in RUN: Stall > DONE > redirect > sequential.
REQ-026 PC SHALL wrap from 2^PC_WIDTH-1 to 0 without a flag.
REQ-027 ImemAddr SHALL equal PC combinationally.

Reset
REQ-028 Reset_n low SHALL asynchronously force state IDLE, PC = 0, Instr = NOP, InstrValid = 0, Done = 0, including during RUN or HALT.
REQ-029 After Reset_n deasserts, the block SHALL remain in IDLE until Start.

Configuration
REQ-030 With FETCH_PERF_EN defined, the block SHALL add outputs CycleCount (32-bit, increments each RUN cycle) and BubbleCount (16-bit, increments per redirect bubble), both cleared by reset and by Start, frozen in HALT; without the macro these ports and counters SHALL not exist.

Structure
REQ-031 Package isa_pkg SHALL hold IW, OP_NOP, OP_DONE, and the fetch state enum type.
REQ-032 The PC register, incrementer, wrap and load mux SHALL be a sub-module named program_counter.

Verification
REQ-033 Reset, then Start; memory 0..2 = add, sub, DONE -> Instr sequence add, sub, DONE on cycles 1..3; Done = 1 on cycle 4; PC = 3.
REQ-034 Instr at address 4 = branch, Branch = 1, BranchTaken = 1, Target = 20 -> next cycle Instr = NOP, InstrValid = 0; following cycle Instr = mem[20].
REQ-035 Same branch with BranchTaken = 0 -> mem[5] follows directly, no bubble.
REQ-036 Stall high for 3 cycles mid-RUN at PC = 7 -> PC and Instr unchanged for 3 cycles; fetch resumes at 7.
REQ-037 PC = 1023 with PC_WIDTH = 10 -> next PC = 0; Reset_n pulsed low mid-RUN -> immediate IDLE, Instr = NOP, Done = 0.
REQ-038 FETCH_PERF_EN defined, program with 2 taken branches and 10 RUN cycles -> BubbleCount = 2, CycleCount = 10 at HALT.
